// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals four cards, resolves naturals and third-card
// draws, then holds the win lights for HOLD_CYCLES cycles before going idle.
module baccarat_round_ctrl #(
  parameter int HOLD_CYCLES = 8,
  parameter bit AUTO_START  = 1'b1,
  parameter bit BANKER_MODE = 1'b0
) (
  input  logic       slowclock,
  input  logic       resetb,
  input  logic       start,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       busy,
  output logic       round_done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEAL_P1,
    S_DEAL_D1,
    S_DEAL_P2,
    S_DEAL_D2,
    S_CHECK_NAT,
    S_DRAW_P3,
    S_BANK_DEC,
    S_DRAW_D3,
    S_SCORE,
    S_HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          banker_draw;

  always_comb begin
    banker_draw = 1'b0;
    if (BANKER_MODE) begin
      banker_draw = (dscore <= 4'd5);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
        4'd3:             banker_draw = (pcard3 != 4'd8);
        4'd4:             banker_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
        4'd5:             banker_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
        4'd6:             banker_draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
        default:          banker_draw = 1'b0;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    case (state)
      S_IDLE:      if (AUTO_START || start) state_nxt = S_DEAL_P1;
      S_DEAL_P1:   state_nxt = S_DEAL_D1;
      S_DEAL_D1:   state_nxt = S_DEAL_P2;
      S_DEAL_P2:   state_nxt = S_DEAL_D2;
      S_DEAL_D2:   state_nxt = S_CHECK_NAT;
      S_CHECK_NAT: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_nxt = S_SCORE;
        else if (pscore <= 4'd5)                  state_nxt = S_DRAW_P3;
        else if (dscore <= 4'd5)                  state_nxt = S_DRAW_D3;
        else                                      state_nxt = S_SCORE;
      end
      S_DRAW_P3:   state_nxt = S_BANK_DEC;
      S_BANK_DEC:  state_nxt = banker_draw ? S_DRAW_D3 : S_SCORE;
      S_DRAW_D3:   state_nxt = S_SCORE;
      S_SCORE:     state_nxt = S_HOLD;
      S_HOLD: begin
        hold_nxt = hold_cnt + CW'(1);
        if (hold_cnt == HOLD_LAST) state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a pure function
  // of the state register in the cycle it is visible.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge slowclock) begin
    if (resetb) begin
      state            <= S_IDLE;
      hold_cnt         <= '0;
      load_pcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      busy             <= 1'b0;
      round_done       <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      load_pcard1 <= (state_nxt == S_DEAL_P1);
      load_dcard1 <= (state_nxt == S_DEAL_D1);
      load_pcard2 <= (state_nxt == S_DEAL_P2);
      load_dcard2 <= (state_nxt == S_DEAL_D2);
      load_pcard3 <= (state_nxt == S_DRAW_P3);
      load_dcard3 <= (state_nxt == S_DRAW_D3);
      busy        <= (state_nxt != S_IDLE);
      round_done  <= (state_nxt == S_HOLD) && (hold_nxt == HOLD_LAST);
      // A tie lights both lamps; the lamps drop as the hold phase ends.
      if (state == S_SCORE) begin
        player_win_light <= (pscore >= dscore);
        dealer_win_light <= (dscore >= pscore);
      end else if (state_nxt != S_HOLD) begin
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Self-checking bench: two configurations of the round controller driven by a
// card/score model; expected per-cycle outputs come from the baccarat rules.
module tb_baccarat_round_ctrl;

  // Observation vector bit order:
  // {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3, plight, dlight, busy, done}
  localparam logic [9:0] V_IDLE = 10'b0000000000;
  localparam logic [9:0] V_BUSY = 10'b0000000010;
  localparam logic [9:0] V_P1   = 10'b1000000010;
  localparam logic [9:0] V_D1   = 10'b0100000010;
  localparam logic [9:0] V_P2   = 10'b0010000010;
  localparam logic [9:0] V_D2   = 10'b0001000010;
  localparam logic [9:0] V_P3   = 10'b0000100010;
  localparam logic [9:0] V_D3   = 10'b0000010010;
  localparam logic [9:0] V_PL   = 10'b0000001000;
  localparam logic [9:0] V_DL   = 10'b0000000100;
  localparam logic [9:0] V_DONE = 10'b0000000001;

  localparam int HOLD_A = 8;
  localparam int HOLD_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, start_a, start_b;
  logic [3:0] ps2, ps3, ds2, ds3, pc3;
  logic       p3_a, d3_a, p3_b, d3_b;
  logic [3:0] pscore_a, dscore_a, pscore_b, dscore_b;
  wire  [9:0] obs_a, obs_b;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  baccarat_round_ctrl #(.HOLD_CYCLES(HOLD_A), .AUTO_START(1'b1), .BANKER_MODE(1'b0)) dut_a (
    .slowclock(clk), .resetb(rst_a), .start(start_a),
    .pscore(pscore_a), .dscore(dscore_a), .pcard3(pc3),
    .load_pcard1(obs_a[9]), .load_dcard1(obs_a[8]), .load_pcard2(obs_a[7]),
    .load_dcard2(obs_a[6]), .load_pcard3(obs_a[5]), .load_dcard3(obs_a[4]),
    .player_win_light(obs_a[3]), .dealer_win_light(obs_a[2]),
    .busy(obs_a[1]), .round_done(obs_a[0])
  );

  baccarat_round_ctrl #(.HOLD_CYCLES(HOLD_B), .AUTO_START(1'b0), .BANKER_MODE(1'b1)) dut_b (
    .slowclock(clk), .resetb(rst_b), .start(start_b),
    .pscore(pscore_b), .dscore(dscore_b), .pcard3(pc3),
    .load_pcard1(obs_b[9]), .load_dcard1(obs_b[8]), .load_pcard2(obs_b[7]),
    .load_dcard2(obs_b[6]), .load_pcard3(obs_b[5]), .load_dcard3(obs_b[4]),
    .player_win_light(obs_b[3]), .dealer_win_light(obs_b[2]),
    .busy(obs_b[1]), .round_done(obs_b[0])
  );

  // External score path: totals reflect the third card from the cycle after its load.
  always @(posedge clk) begin
    if (rst_a || obs_a[9]) p3_a <= 1'b0; else if (obs_a[5]) p3_a <= 1'b1;
    if (rst_a || obs_a[8]) d3_a <= 1'b0; else if (obs_a[4]) d3_a <= 1'b1;
    if (rst_b || obs_b[9]) p3_b <= 1'b0; else if (obs_b[5]) p3_b <= 1'b1;
    if (rst_b || obs_b[8]) d3_b <= 1'b0; else if (obs_b[4]) d3_b <= 1'b1;
  end
  assign pscore_a = p3_a ? ps3 : ps2;
  assign dscore_a = d3_a ? ds3 : ds2;
  assign pscore_b = p3_b ? ps3 : ps2;
  assign dscore_b = d3_b ? ds3 : ds2;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  function automatic bit banker_draws(input bit simple, input logic [3:0] d, input logic [3:0] c);
    if (simple) return d <= 4'd5;
    if (d <= 4'd2) return 1'b1;
    if (d == 4'd3) return c != 4'd8;
    if (d == 4'd4) return c >= 4'd2 && c <= 4'd7;
    if (d == 4'd5) return c >= 4'd4 && c <= 4'd7;
    if (d == 4'd6) return c >= 4'd6 && c <= 4'd7;
    return 1'b0;
  endfunction

  // Expected cycle-by-cycle outputs for one round, from the first deal cycle to the last hold cycle.
  task automatic build_exp(input bit simple, input int hold);
    bit         pdraw, bdraw;
    logic [3:0] pf, df;
    logic [9:0] lights;
    exp_q.delete();
    exp_q.push_back(V_P1);
    exp_q.push_back(V_D1);
    exp_q.push_back(V_P2);
    exp_q.push_back(V_D2);
    exp_q.push_back(V_BUSY);
    pdraw = 1'b0;
    bdraw = 1'b0;
    if (!(ps2 >= 4'd8 || ds2 >= 4'd8)) begin
      if (ps2 <= 4'd5) begin
        pdraw = 1'b1;
        bdraw = banker_draws(simple, ds2, pc3);
      end else begin
        bdraw = (ds2 <= 4'd5);
      end
    end
    if (pdraw) begin
      exp_q.push_back(V_P3);
      exp_q.push_back(V_BUSY);
    end
    if (bdraw) exp_q.push_back(V_D3);
    exp_q.push_back(V_BUSY);
    pf = pdraw ? ps3 : ps2;
    df = bdraw ? ds3 : ds2;
    lights = (pf > df) ? V_PL : (pf < df) ? V_DL : (V_PL | V_DL);
    for (int h = 0; h < hold; h++)
      exp_q.push_back(V_BUSY | lights | ((h == hold - 1) ? V_DONE : V_IDLE));
  endtask

  task automatic set_round(input logic [3:0] a, b, c, d, e);
    ps2 = a; ps3 = b; ds2 = c; ds3 = d; pc3 = e;
  endtask

  task automatic rand_round();
    int c[6];
    for (int k = 0; k < 6; k++) c[k] = int'($urandom_range(0, 9));
    ps2 = 4'((c[0] + c[1]) % 10);
    ps3 = 4'((c[0] + c[1] + c[2]) % 10);
    pc3 = 4'(c[2]);
    ds2 = 4'((c[3] + c[4]) % 10);
    ds3 = 4'((c[3] + c[4] + c[5]) % 10);
  endtask

  // Compares every cycle of the expected round plus the idle cycle that follows.
  task automatic run_round(input bit which, input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i + 1), which ? obs_b : obs_a, exp_q[i]);
      if (which) start_b = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s idle", tag), which ? obs_b : obs_a, V_IDLE);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    set_round(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("reset_a", obs_a, V_IDLE);
    check("reset_b", obs_b, V_IDLE);

    // Full tableau, auto-start: rounds run back to back.
    set_round(4'd8, 4'd8, 4'd8, 4'd8, 4'd0);
    build_exp(1'b0, HOLD_A);
    rst_a = 1'b0;
    run_round(1'b0, "a_natural_tie");
    set_round(4'd3, 4'd9, 4'd6, 4'd4, 4'd6);
    build_exp(1'b0, HOLD_A);
    run_round(1'b0, "a_both_draw");
    set_round(4'd2, 4'd0, 4'd3, 4'd3, 4'd8);
    build_exp(1'b0, HOLD_A);
    run_round(1'b0, "a_bank_stand_3_8");
    set_round(4'd7, 4'd7, 4'd5, 4'd9, 4'd0);
    build_exp(1'b0, HOLD_A);
    run_round(1'b0, "a_player_stand");
    set_round(4'd12, 4'd12, 4'd3, 4'd3, 4'd0);
    build_exp(1'b0, HOLD_A);
    run_round(1'b0, "a_oor_natural");
    set_round(4'd4, 4'd13, 4'd7, 4'd7, 4'd9);
    build_exp(1'b0, HOLD_A);
    run_round(1'b0, "a_oor_third");
    for (int r = 0; r < 40; r++) begin
      rand_round();
      build_exp(1'b0, HOLD_A);
      run_round(1'b0, $sformatf("a_rand%0d", r));
    end
    rst_a = 1'b1;

    // Simplified banker, start-driven, short hold.
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("b_wait%0d", i), obs_b, V_IDLE);
    end
    set_round(4'd2, 4'd0, 4'd3, 4'd3, 4'd8);
    build_exp(1'b1, HOLD_B);
    start_b = 1'b1;
    run_round(1'b1, "b_bank_draw_3_8");
    for (int r = 0; r < 20; r++) begin
      rand_round();
      build_exp(1'b1, HOLD_B);
      start_b = 1'b1;
      run_round(1'b1, $sformatf("b_rand%0d", r));
    end

    // Abort during the player's third-card load.
    set_round(4'd2, 4'd5, 4'd1, 4'd1, 4'd3);
    build_exp(1'b1, HOLD_B);
    start_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b_abort cyc%0d", i + 1), obs_b, exp_q[i]);
      start_b = 1'b0;
    end
    rst_b = 1'b1;
    @(negedge clk);
    check("b_abort reset", obs_b, V_IDLE);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b_abort idle%0d", i), obs_b, V_IDLE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baccarat_round_ctrl.md
# baccarat_round_ctrl

Parametrised successor to the baccarat dealing sequencer. It runs a complete round: deals the four opening cards, checks for naturals, applies the player and banker third-card rules, and drives the win lights. Each light is held for a programmable time, then the block returns to idle. It sits between the card-load registers and the external score datapath, which supplies `pscore`, `dscore` and `pcard3`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 8: number of cycles the result lights stay asserted (≥1).
- `AUTO_START`, default 1: 1 = start a new round straight from IDLE; 0 = wait in IDLE for `start`.
- `BANKER_MODE`, default 0: 0 = full banker tableau; 1 = simplified, where the banker draws on 0–5 regardless of `pcard3`.

Ports (one clock; reset is synchronous and active-high):
- `slowclock` in 1: the single clock; all state changes on its rising edge.
- `resetb` in 1: synchronous, active-high reset (despite the name).
- `start` in 1: round request, sampled only in IDLE and ignored when `AUTO_START`=1.
- `pscore` in 4: player hand total, 0–9, valid the cycle after a load.
- `dscore` in 4: banker hand total, 0–9.
- `pcard3` in 4: value of the player's third card, 0–9.
- `load_pcard1`, `load_pcard2`, `load_pcard3`, `load_dcard1`, `load_dcard2`, `load_dcard3` out 1 each: one-cycle card-load strobes.
- `player_win_light`, `dealer_win_light` out 1 each: result lights; both high means a tie.
- `busy` out 1: high in every state except IDLE.
- `round_done` out 1: one-cycle pulse in the last HOLD cycle.

## Operation
- All outputs are Moore-decoded from the registered state and hold counter, so there are no combinational paths from inputs.
- Reset:
  - state goes to IDLE and the hold counter clears;
  - every output is 0 in the cycle after the reset edge;
  - asserting reset mid-round aborts the round and no further load strobes occur.
- States and transitions:
  - IDLE → DEAL_P1 when `AUTO_START`=1 or `start`=1.
  - The deal runs DEAL_P1 (`load_pcard1`) → DEAL_D1 (`load_dcard1`) → DEAL_P2 (`load_pcard2`) → DEAL_D2 (`load_dcard2`) → CHECK_NAT.
  - CHECK_NAT (no strobes; scores valid):
    - `pscore`≥8 or `dscore`≥8 → SCORE;
    - else `pscore`≤5 → DRAW_P3;
    - else (player stands on 6–7) `dscore`≤5 → DRAW_D3;
    - else → SCORE.
  - DRAW_P3 (`load_pcard3`) → BANK_DEC.
  - BANK_DEC evaluates the banker draw rule using `dscore` and `pcard3`; draw → DRAW_D3, else → SCORE.
  - DRAW_D3 (`load_dcard3`) → SCORE.
  - SCORE registers the lights:
    - `pscore`>`dscore` → player light only;
    - `pscore`<`dscore` → dealer light only;
    - equal → both lights.
  - SCORE → HOLD.
  - HOLD keeps the lights for `HOLD_CYCLES` cycles; `round_done` is high in the final one; then → IDLE with the lights cleared.
- Banker rule when `BANKER_MODE`=0 (banker draws if):
  - `dscore` 0–2: always;
  - 3: `pcard3`≠8;
  - 4: `pcard3` 2–7;
  - 5: `pcard3` 4–7;
  - 6: `pcard3` 6–7;
  - 7: never.
- Banker rule when `BANKER_MODE`=1: banker draws iff `dscore`≤5.
- Arithmetic and width rules:
  - Comparisons are 4-bit unsigned.
  - Out-of-range input values (10–15) are not clamped and compare numerically.
  - Natural means a value ≥8.
- At most one load strobe is high in any cycle.

## Timing
- Cycle 1 is the first DEAL_P1 cycle.
- Latency to the lights (first HOLD cycle):
  - natural: CHECK_NAT is cycle 5 and SCORE cycle 6, so the lights are high from cycle 7;
  - player stands and banker draws: DRAW_D3 in cycle 6, lights from cycle 8;
  - both draw: DRAW_P3 6, BANK_DEC 7, DRAW_D3 8, SCORE 9, lights from cycle 10;
  - player draws and banker stands: lights from cycle 9.
- The lights stay high for exactly `HOLD_CYCLES` cycles; IDLE follows with the lights low.
- With `AUTO_START`=1, the next DEAL_P1 comes one cycle after IDLE.
- Scores are sampled in the cycle after the corresponding strobe, so the external card register and score path must settle within one cycle.

## Test plan
- Reset asserted mid DRAW_P3: all outputs 0 the next cycle, state returns to IDLE, no `load_dcard3`. With `AUTO_START`=0 and `start`=0 after release, the block stays idle.
- Natural tie, `pscore`=8 and `dscore`=8 at CHECK_NAT: strobe order P1, D1, P2, D2; both lights high in cycles 7–14 (`HOLD_CYCLES`=8); `round_done` in cycle 14; no third-card strobes.
- `pscore`=3 then 9 after pcard3, `pcard3`=6, `dscore`=6: `load_pcard3` in cycle 6, `load_dcard3` in cycle 8; with final `dscore`=4, player light only from cycle 10.
- `dscore`=3 and `pcard3`=8 with `BANKER_MODE`=0: banker stands, no `load_dcard3`. Same values with `BANKER_MODE`=1: `load_dcard3` in cycle 8.
- Player stands, `pscore`=7 and `dscore`=5: `load_dcard3` in cycle 6. With final `dscore`=9: dealer light only from cycle 8.
- `AUTO_START`=0: `start` pulsed while busy is ignored. After return to IDLE, a `start` pulse gives DEAL_P1 exactly one cycle later, and `busy` goes high with it.
